axi4_lite_slave: RTL and testbench
==================================

// Module: axi4_lite_slave
// PURPOSE
//  AXI4-Lite slave front end for the adder peripheral; sits directly upstream of the register file.
//  Terminates AW/W/B and AR/R channels and turns write handshakes into a one-cycle register write strobe.
//  Services reads through the register file's combinational read port.
//  Write and read channels are independent FSMs sharing only clock and reset.
// PARAMETERS
//  ADDR_W    32  AXI address width
//  DATA_W    32  AXI data width
//  NUM_REGS  5   implemented words; word index = addr[7:2], valid range 0..NUM_REGS-1
// PORTS
//  ACLK             in   1       clock, all logic on rising edge
//  ARSTn            in   1       asynchronous active-low reset
//  AWADDR/AWVALID   in   32/1    write address channel; AWREADY out 1
//  AWPROT           in   3       ignored
//  WDATA/WVALID     in   32/1    write data channel; WREADY out 1
//  WSTRB            in   4       ignored, every write is a full word
//  BRESP/BVALID     out  2/1     write response; BREADY in 1
//  ARADDR/ARVALID   in   32/1    read address channel; ARREADY out 1
//  ARPROT           in   3       ignored
//  RDATA/RRESP      out  32/2    read data and response
//  RVALID           out  1       read valid; RREADY in 1
//  o_addr_wc        out  32      latched write address to register file
//  o_data_wc        out  32      latched write data to register file
//  o_en_amba_write  out  1       one-cycle write strobe to register file
//  o_addr_rc        out  32      latched read address to register file
//  i_data_rc        in   32      combinational read data from register file
// BEHAVIOUR
//  Reset (async assert, sync release): every output 0 except AWREADY=WREADY=ARREADY=1; both FSMs to IDLE.
//  Reset mid-transaction drops all pending state; no strobe and no response is issued afterwards.
//  Write FSM: W_IDLE -> W_EXEC -> W_RESP -> W_IDLE.
//   - AWREADY=1 while no address is held; WREADY=1 while no data is held.
//   - AW and W are captured independently, in either order or in the same cycle.
//   - Once both are held: W_EXEC asserts o_en_amba_write for exactly 1 cycle; o_addr_wc/o_data_wc stay stable.
//   - W_RESP: BVALID=1, held until the BREADY handshake, then both holding flags clear.
//   - Minimum latency: AW+W handshake at edge N; strobe high in cycle N..N+1; BVALID high from edge N+1.
//   - While holding or responding, the corresponding READY=0; a second AW waits, never overwrites.
//  Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
//   - ARREADY=1 only in R_IDLE; ARADDR is latched into o_addr_rc on handshake.
//   - R_ADDR: RDATA <= i_data_rc.
//   - R_DATA: RVALID=1 with RDATA stable until RREADY. RVALID rises 2 edges after the AR handshake.
//  Simultaneous write strobe and read capture on the same word: the read returns the pre-write value.
//  BRESP/RRESP = 2'b00 (OKAY) except as defined under CONFIGURATION.
// CONFIGURATION
//  AXI_SLVERR_EN defined: an address with word index >= NUM_REGS is out of range.
//   - Out-of-range write: no o_en_amba_write pulse, BRESP=2'b10.
//   - Out-of-range read: RDATA=0, RRESP=2'b10.
//   - Timing of both is identical to in-range accesses.
//  AXI_SLVERR_EN undefined: responses are always OKAY.
//   - Out-of-range writes still pulse the strobe; the register file discards them.
//   - Out-of-range reads return i_data_rc unmodified.
// STRUCTURE
//  Package axi4_lite_pkg holds:
//   - resp_t enum: OKAY=2'b00, SLVERR=2'b10
//   - wr_state_t and rd_state_t enums
//   - localparams REG_IDX_MSB=7, REG_IDX_LSB=2
//  The read channel is one natural sub-module, axi4_lite_rd_channel: AR/R FSM plus o_addr_rc and RDATA registers.
//  The write FSM stays inline in axi4_lite_slave.
// TESTING
//  1. AW=0x0 and W=0x0000_0007 in the same cycle, BREADY=1
//     -> one strobe with o_addr_wc=0x0, o_data_wc=7; BVALID one cycle later with BRESP=0.
//  2. W=0xA5 three cycles before AW=0x4
//     -> WREADY low after the W capture; one strobe addr 0x4 data 0xA5; exactly one B response.
//  3. AR=0x8 with i_data_rc=0x1234, RREADY held low for 4 cycles
//     -> RVALID held with RDATA=0x1234 stable until RREADY; ARREADY=0 throughout.
//  4. Write 0xC to addr 0x0C and read addr 0x0C issued in the same cycle -> read returns the old value.
//  5. With AXI_SLVERR_EN: write addr 0x40 -> no strobe, BRESP=2'b10; read addr 0x14 -> RDATA=0, RRESP=2'b10.
//     Without AXI_SLVERR_EN: both responses OKAY.
//  6. ARSTn pulsed low during W_RESP and R_DATA
//     -> BVALID=RVALID=0 immediately; READYs return to 1; no late strobe.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types and address-decode helpers for the adder peripheral AXI4-Lite front end.
// Build option AXI_SLVERR_EN (used by the importing modules) enables SLVERR on out-of-range words.
package axi4_lite_pkg;

    localparam int REG_IDX_MSB = 7;
    localparam int REG_IDX_LSB = 2;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_t;

    function automatic logic word_in_range(input logic [REG_IDX_MSB:REG_IDX_LSB] idx,
                                           input int num_regs);
        return int'(idx) < num_regs;
    endfunction

endpackage

// File: rtl/axi4_lite_rd_channel.sv
// AR/R channel of the AXI4-Lite slave: latches the read address and returns register-file data.
// Build option AXI_SLVERR_EN: out-of-range reads return zero data with SLVERR.
module axi4_lite_rd_channel
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 5
) (
    input  logic              ACLK,
    input  logic              ARSTn,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [ADDR_W-1:0] o_addr_rc,
    input  logic [DATA_W-1:0] i_data_rc
);

`ifdef AXI_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    rd_state_t rd_state;
    logic      rd_err;
    logic      ar_bad;

    always_comb begin
        ar_bad = SLVERR_EN && !word_in_range(ARADDR[REG_IDX_MSB:REG_IDX_LSB], NUM_REGS);
    end

    // RDATA is sampled one edge after o_addr_rc settles, and RVALID follows one edge later.
    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            rd_state  <= R_IDLE;
            ARREADY   <= 1'b1;
            RVALID    <= 1'b0;
            RRESP     <= OKAY;
            RDATA     <= '0;
            o_addr_rc <= '0;
            rd_err    <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ARVALID) begin
                        o_addr_rc <= ARADDR;
                        ARREADY   <= 1'b0;
                        rd_err    <= ar_bad;
                        rd_state  <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    RDATA    <= rd_err ? '0 : i_data_rc;
                    RRESP    <= rd_err ? SLVERR : OKAY;
                    rd_state <= R_DATA;
                end
                R_DATA: begin
                    if (!RVALID) begin
                        RVALID <= 1'b1;
                    end else if (RREADY) begin
                        RVALID   <= 1'b0;
                        RRESP    <= OKAY;
                        ARREADY  <= 1'b1;
                        rd_state <= R_IDLE;
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave for the adder peripheral: write FSM inline, read channel in axi4_lite_rd_channel.
// Build option AXI_SLVERR_EN: out-of-range writes are dropped and answered with SLVERR.
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 5
) (
    input  logic                ACLK,
    input  logic                ARSTn,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [2:0]          AWPROT,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic                WVALID,
    output logic                WREADY,
    input  logic [DATA_W/8-1:0] WSTRB,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic                ARVALID,
    output logic                ARREADY,
    input  logic [2:0]          ARPROT,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [ADDR_W-1:0]   o_addr_wc,
    output logic [DATA_W-1:0]   o_data_wc,
    output logic                o_en_amba_write,
    output logic [ADDR_W-1:0]   o_addr_rc,
    input  logic [DATA_W-1:0]   i_data_rc
);

`ifdef AXI_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    wr_state_t         wr_state;
    logic              wr_err;
    logic              aw_hs;
    logic              w_hs;
    logic              aw_have;
    logic              w_have;
    logic              wr_ok;
    logic [ADDR_W-1:0] wr_addr_next;
    logic              unused_ok;

    assign unused_ok = ^{AWPROT, WSTRB, ARPROT};

    // A READY that is low means the matching half of the write is already held.
    always_comb begin
        aw_hs        = AWVALID && AWREADY;
        w_hs         = WVALID && WREADY;
        aw_have      = aw_hs || !AWREADY;
        w_have       = w_hs || !WREADY;
        wr_addr_next = aw_hs ? AWADDR : o_addr_wc;
        wr_ok        = !SLVERR_EN || word_in_range(wr_addr_next[REG_IDX_MSB:REG_IDX_LSB], NUM_REGS);
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            wr_state        <= W_IDLE;
            AWREADY         <= 1'b1;
            WREADY          <= 1'b1;
            BVALID          <= 1'b0;
            BRESP           <= OKAY;
            o_addr_wc       <= '0;
            o_data_wc       <= '0;
            o_en_amba_write <= 1'b0;
            wr_err          <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        o_addr_wc <= AWADDR;
                        AWREADY   <= 1'b0;
                    end
                    if (w_hs) begin
                        o_data_wc <= WDATA;
                        WREADY    <= 1'b0;
                    end
                    if (aw_have && w_have) begin
                        o_en_amba_write <= wr_ok;
                        wr_err          <= !wr_ok;
                        wr_state        <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    o_en_amba_write <= 1'b0;
                    BVALID          <= 1'b1;
                    BRESP           <= wr_err ? SLVERR : OKAY;
                    wr_state        <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID   <= 1'b0;
                        BRESP    <= OKAY;
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: begin
                    wr_state <= W_IDLE;
                end
            endcase
        end
    end

    axi4_lite_rd_channel #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd_channel (
        .ACLK      (ACLK),
        .ARSTn     (ARSTn),
        .ARADDR    (ARADDR),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .o_addr_rc (o_addr_rc),
        .i_data_rc (i_data_rc)
    );

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed self-checking bench for axi4_lite_slave with a small register-file model on the read port.
// Expected SLVERR behaviour follows the AXI_SLVERR_EN build option.
module tb_axi4_lite_slave;

    logic        ACLK;
    logic        ARSTn;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [2:0]  AWPROT;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [2:0]  ARPROT;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] o_addr_wc;
    logic [31:0] o_data_wc;
    logic        o_en_amba_write;
    logic [31:0] o_addr_rc;
    logic [31:0] i_data_rc;

    int compared   = 0;
    int mismatched = 0;
    int strobe_count = 0;
    int b_count      = 0;
    int r_count      = 0;

    logic [31:0] regs [5];
    logic [5:0]  rd_idx;
    logic [5:0]  wr_idx;

`ifdef AXI_SLVERR_EN
    localparam bit EXP_SLVERR = 1'b1;
`else
    localparam bit EXP_SLVERR = 1'b0;
`endif

    axi4_lite_slave dut (
        .ACLK            (ACLK),
        .ARSTn           (ARSTn),
        .AWADDR          (AWADDR),
        .AWVALID         (AWVALID),
        .AWREADY         (AWREADY),
        .AWPROT          (AWPROT),
        .WDATA           (WDATA),
        .WVALID          (WVALID),
        .WREADY          (WREADY),
        .WSTRB           (WSTRB),
        .BRESP           (BRESP),
        .BVALID          (BVALID),
        .BREADY          (BREADY),
        .ARADDR          (ARADDR),
        .ARVALID         (ARVALID),
        .ARREADY         (ARREADY),
        .ARPROT          (ARPROT),
        .RDATA           (RDATA),
        .RRESP           (RRESP),
        .RVALID          (RVALID),
        .RREADY          (RREADY),
        .o_addr_wc       (o_addr_wc),
        .o_data_wc       (o_data_wc),
        .o_en_amba_write (o_en_amba_write),
        .o_addr_rc       (o_addr_rc),
        .i_data_rc       (i_data_rc)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Register-file model: written by the strobe, read combinationally through o_addr_rc.
    assign wr_idx = o_addr_wc[7:2];
    assign rd_idx = o_addr_rc[7:2];

    always @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            for (int i = 0; i < 5; i++) regs[i] <= 32'h0;
        end else if (o_en_amba_write && wr_idx < 6'd5) begin
            regs[wr_idx[2:0]] <= o_data_wc;
        end
    end

    always_comb begin
        i_data_rc = 32'hDEAD_BEEF;
        if (rd_idx < 6'd5) i_data_rc = regs[rd_idx[2:0]];
    end

    always @(posedge ACLK) begin
        if (ARSTn && o_en_amba_write) strobe_count++;
        if (ARSTn && BVALID && BREADY) b_count++;
        if (ARSTn && RVALID && RREADY) r_count++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle of channel inputs, then returns 1ns after the sampling edge.
    task automatic applyStimulus(input logic awv, input logic [31:0] awa,
                                 input logic wv, input logic [31:0] wd,
                                 input logic arv, input logic [31:0] ara,
                                 input logic br, input logic rr);
        AWVALID = awv;
        AWADDR  = awa;
        WVALID  = wv;
        WDATA   = wd;
        ARVALID = arv;
        ARADDR  = ara;
        BREADY  = br;
        RREADY  = rr;
        @(posedge ACLK);
        #1;
    endtask

    task automatic idleCycle(input logic br, input logic rr);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, br, rr);
    endtask

    task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           output logic [1:0] resp);
        applyStimulus(1'b1, addr, 1'b1, data, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 10 && !BVALID; i++) idleCycle(1'b1, 1'b0);
        checkOutput({tag, "_bvalid"}, 32'(BVALID), 32'h1);
        resp = BRESP;
        idleCycle(1'b1, 1'b0);
    endtask

    task automatic doRead(input string tag, input logic [31:0] addr,
                          output logic [31:0] data, output logic [1:0] resp);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, addr, 1'b1, 1'b0);
        for (int i = 0; i < 10 && !RVALID; i++) idleCycle(1'b1, 1'b0);
        checkOutput({tag, "_rvalid"}, 32'(RVALID), 32'h1);
        data = RDATA;
        resp = RRESP;
        idleCycle(1'b1, 1'b1);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        int s0;
        int b0;
        int r0;

        ARSTn   = 1'b0;
        AWPROT  = 3'b000;
        ARPROT  = 3'b000;
        WSTRB   = 4'hF;
        AWVALID = 1'b0;
        AWADDR  = 32'h0;
        WVALID  = 1'b0;
        WDATA   = 32'h0;
        ARVALID = 1'b0;
        ARADDR  = 32'h0;
        BREADY  = 1'b0;
        RREADY  = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("rst_awready", 32'(AWREADY), 32'h1);
        checkOutput("rst_wready", 32'(WREADY), 32'h1);
        checkOutput("rst_arready", 32'(ARREADY), 32'h1);
        checkOutput("rst_bvalid", 32'(BVALID), 32'h0);
        checkOutput("rst_rvalid", 32'(RVALID), 32'h0);
        checkOutput("rst_strobe", 32'(o_en_amba_write), 32'h0);
        checkOutput("rst_rdata", RDATA, 32'h0);
        checkOutput("rst_resps", {28'h0, BRESP, RRESP}, 32'h0);
        checkOutput("rst_addr_rc", o_addr_rc, 32'h0);
        #4 ARSTn = 1'b1;
        @(posedge ACLK);
        #1;

        $display("[TB] test 1: AW and W in the same cycle");
        s0 = strobe_count;
        b0 = b_count;
        applyStimulus(1'b1, 32'h0, 1'b1, 32'h7, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("t1_strobe", 32'(o_en_amba_write), 32'h1);
        checkOutput("t1_addr_wc", o_addr_wc, 32'h0);
        checkOutput("t1_data_wc", o_data_wc, 32'h7);
        checkOutput("t1_readys_low", {30'h0, AWREADY, WREADY}, 32'h0);
        checkOutput("t1_bvalid_early", 32'(BVALID), 32'h0);
        idleCycle(1'b1, 1'b0);
        checkOutput("t1_strobe_off", 32'(o_en_amba_write), 32'h0);
        checkOutput("t1_bvalid", 32'(BVALID), 32'h1);
        checkOutput("t1_bresp", 32'(BRESP), 32'h0);
        checkOutput("t1_data_stable", o_data_wc, 32'h7);
        idleCycle(1'b1, 1'b0);
        checkOutput("t1_bvalid_done", 32'(BVALID), 32'h0);
        checkOutput("t1_readys_back", {30'h0, AWREADY, WREADY}, 32'h3);
        checkOutput("t1_strobe_count", 32'(strobe_count - s0), 32'h1);
        checkOutput("t1_b_count", 32'(b_count - b0), 32'h1);

        $display("[TB] test 2: W three cycles before AW");
        s0 = strobe_count;
        b0 = b_count;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hA5, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("t2_wready_low", 32'(WREADY), 32'h0);
        checkOutput("t2_awready_high", 32'(AWREADY), 32'h1);
        for (int i = 0; i < 2; i++) begin
            idleCycle(1'b1, 1'b0);
            checkOutput("t2_no_early_strobe", 32'(o_en_amba_write), 32'h0);
        end
        applyStimulus(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("t2_strobe", 32'(o_en_amba_write), 32'h1);
        checkOutput("t2_addr_wc", o_addr_wc, 32'h4);
        checkOutput("t2_data_wc", o_data_wc, 32'hA5);
        repeat (3) idleCycle(1'b1, 1'b0);
        checkOutput("t2_strobe_count", 32'(strobe_count - s0), 32'h1);
        checkOutput("t2_b_count", 32'(b_count - b0), 32'h1);

        $display("[TB] test 3: read with RREADY held low");
        doWrite("t3_prep", 32'h8, 32'h1234, resp);
        r0 = r_count;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b0);
        checkOutput("t3_arready_low", 32'(ARREADY), 32'h0);
        checkOutput("t3_addr_rc", o_addr_rc, 32'h8);
        checkOutput("t3_rvalid_edge1", 32'(RVALID), 32'h0);
        idleCycle(1'b1, 1'b0);
        checkOutput("t3_rvalid_edge2", 32'(RVALID), 32'h0);
        idleCycle(1'b1, 1'b0);
        checkOutput("t3_rvalid", 32'(RVALID), 32'h1);
        checkOutput("t3_rdata", RDATA, 32'h1234);
        checkOutput("t3_rresp", 32'(RRESP), 32'h0);
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b1, 1'b0);
            checkOutput("t3_rvalid_hold", 32'(RVALID), 32'h1);
            checkOutput("t3_rdata_hold", RDATA, 32'h1234);
            checkOutput("t3_arready_hold", 32'(ARREADY), 32'h0);
        end
        idleCycle(1'b1, 1'b1);
        checkOutput("t3_rvalid_done", 32'(RVALID), 32'h0);
        checkOutput("t3_arready_back", 32'(ARREADY), 32'h1);
        checkOutput("t3_r_count", 32'(r_count - r0), 32'h1);

        $display("[TB] test 4: write and read of the same word together");
        doWrite("t4_prep", 32'hC, 32'h55, resp);
        applyStimulus(1'b1, 32'hC, 1'b1, 32'hC, 1'b1, 32'hC, 1'b1, 1'b0);
        for (int i = 0; i < 10 && !RVALID; i++) idleCycle(1'b1, 1'b0);
        checkOutput("t4_rvalid", 32'(RVALID), 32'h1);
        checkOutput("t4_old_value", RDATA, 32'h55);
        idleCycle(1'b1, 1'b1);
        doRead("t4_reread", 32'hC, data, resp);
        checkOutput("t4_new_value", data, 32'hC);

        $display("[TB] test 5: out-of-range accesses");
        s0 = strobe_count;
        doWrite("t5_wr", 32'h40, 32'h99, resp);
        checkOutput("t5_bresp", 32'(resp), EXP_SLVERR ? 32'h2 : 32'h0);
        checkOutput("t5_strobe_count", 32'(strobe_count - s0), EXP_SLVERR ? 32'h0 : 32'h1);
        doRead("t5_rd", 32'h14, data, resp);
        checkOutput("t5_rdata", data, EXP_SLVERR ? 32'h0 : 32'hDEAD_BEEF);
        checkOutput("t5_rresp", 32'(resp), EXP_SLVERR ? 32'h2 : 32'h0);
        doRead("t5_inrange", 32'h4, data, resp);
        checkOutput("t5_inrange_rdata", data, 32'hA5);
        checkOutput("t5_inrange_rresp", 32'(resp), 32'h0);

        $display("[TB] test 6: reset during W_RESP and R_DATA");
        applyStimulus(1'b1, 32'h10, 1'b1, 32'h77, 1'b1, 32'h10, 1'b0, 1'b0);
        idleCycle(1'b0, 1'b0);
        idleCycle(1'b0, 1'b0);
        checkOutput("t6_pre_bvalid", 32'(BVALID), 32'h1);
        checkOutput("t6_pre_rvalid", 32'(RVALID), 32'h1);
        s0 = strobe_count;
        b0 = b_count;
        r0 = r_count;
        #2 ARSTn = 1'b0;
        #1;
        checkOutput("t6_bvalid_clr", 32'(BVALID), 32'h0);
        checkOutput("t6_rvalid_clr", 32'(RVALID), 32'h0);
        checkOutput("t6_readys", {29'h0, AWREADY, WREADY, ARREADY}, 32'h7);
        checkOutput("t6_addr_wc_clr", o_addr_wc, 32'h0);
        #3 ARSTn = 1'b1;
        @(posedge ACLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b1, 1'b1);
            checkOutput("t6_no_late_strobe", 32'(o_en_amba_write), 32'h0);
        end
        checkOutput("t6_strobe_count", 32'(strobe_count - s0), 32'h0);
        checkOutput("t6_b_count", 32'(b_count - b0), 32'h0);
        checkOutput("t6_r_count", 32'(r_count - r0), 32'h0);
        checkOutput("t6_readys_after", {29'h0, AWREADY, WREADY, ARREADY}, 32'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
